// File: rtl/mesi_isc_breq_arb_if.sv
// rtl/mesi_isc_breq_arb_if.sv - CPU command sampling and broadcast FIFO write bundle for the request arbiter
interface mesi_isc_breq_arb_if #(
    parameter int MBUS_CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 5
);
    logic [4*MBUS_CMD_WIDTH-1:0] mbus_cmd_array_i;
    logic [4*ADDR_WIDTH-1:0]     mbus_addr_array_i;
    logic                        broad_fifo_full_i;
    logic [3:0]                  mbus_ack_array_o;
    logic                        broad_fifo_wr_o;
    logic [ADDR_WIDTH-1:0]       broad_addr_o;
    logic [BROAD_TYPE_WIDTH-1:0] broad_type_o;
    logic [1:0]                  broad_cpu_id_o;
    logic [BROAD_ID_WIDTH-1:0]   broad_id_o;

    modport master (
        output mbus_cmd_array_i, mbus_addr_array_i, broad_fifo_full_i,
        input  mbus_ack_array_o, broad_fifo_wr_o, broad_addr_o,
               broad_type_o, broad_cpu_id_o, broad_id_o
    );

    modport slave (
        input  mbus_cmd_array_i, mbus_addr_array_i, broad_fifo_full_i,
        output mbus_ack_array_o, broad_fifo_wr_o, broad_addr_o,
               broad_type_o, broad_cpu_id_o, broad_id_o
    );
endinterface

// File: rtl/mesi_isc_breq_arb.sv
// rtl/mesi_isc_breq_arb.sv - round-robin arbiter feeding broadcast requests into the broadcast FIFO
module mesi_isc_breq_arb #(
    parameter int MBUS_CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 5
) (
    input  logic               clk,
    input  logic               rst,
    mesi_isc_breq_arb_if.slave bus
);
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WR_BROAD = MBUS_CMD_WIDTH'(3);
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RD_BROAD = MBUS_CMD_WIDTH'(4);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, COOL = 2'd2} state_t;

    state_t                      state, state_next;
    logic [1:0]                  ptr, ptr_next;
    logic [BROAD_ID_WIDTH-1:0]   id_cnt, id_cnt_next;

    logic [MBUS_CMD_WIDTH-1:0]   cpu_cmd [4];
    logic [ADDR_WIDTH-1:0]       cpu_addr [4];
    logic [3:0]                  req;
    logic                        found;
    logic [1:0]                  win;
    logic [1:0]                  scan_idx;

    logic [3:0]                  ack_q, ack_next;
    logic                        wr_q, wr_next;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_next;
    logic [BROAD_TYPE_WIDTH-1:0] type_q, type_next;
    logic [1:0]                  cpu_q, cpu_next;
    logic [BROAD_ID_WIDTH-1:0]   id_q, id_next;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            cpu_cmd[n]  = bus.mbus_cmd_array_i[n*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
            cpu_addr[n] = bus.mbus_addr_array_i[n*ADDR_WIDTH +: ADDR_WIDTH];
            req[n]      = (cpu_cmd[n] == CMD_WR_BROAD) || (cpu_cmd[n] == CMD_RD_BROAD);
        end
    end

    // Scan upward from the priority pointer, wrapping modulo 4.
    always_comb begin
        found    = 1'b0;
        win      = ptr;
        scan_idx = ptr;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr + 2'(k);
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
    end

    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        id_cnt_next = id_cnt;
        wr_next     = 1'b0;
        ack_next    = 4'b0000;
        addr_next   = addr_q;
        type_next   = type_q;
        cpu_next    = cpu_q;
        id_next     = id_q;
        case (state)
            IDLE: begin
                if (!bus.broad_fifo_full_i && found) begin
                    state_next = ISSUE;
                    wr_next    = 1'b1;
                    ack_next   = 4'b0001 << win;
                    addr_next  = cpu_addr[win];
                    type_next  = (cpu_cmd[win] == CMD_WR_BROAD) ? BROAD_TYPE_WIDTH'(1)
                                                                : BROAD_TYPE_WIDTH'(2);
                    cpu_next   = win;
                    id_next    = id_cnt;
                end
            end
            ISSUE: begin
                state_next  = COOL;
                id_cnt_next = id_cnt + BROAD_ID_WIDTH'(1);
                ptr_next    = cpu_q + 2'd1;
            end
            COOL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ptr    <= 2'd0;
            id_cnt <= '0;
            ack_q  <= 4'b0000;
            wr_q   <= 1'b0;
            addr_q <= '0;
            type_q <= '0;
            cpu_q  <= 2'd0;
            id_q   <= '0;
        end else begin
            state  <= state_next;
            ptr    <= ptr_next;
            id_cnt <= id_cnt_next;
            ack_q  <= ack_next;
            wr_q   <= wr_next;
            addr_q <= addr_next;
            type_q <= type_next;
            cpu_q  <= cpu_next;
            id_q   <= id_next;
        end
    end

    assign bus.mbus_ack_array_o = ack_q;
    assign bus.broad_fifo_wr_o  = wr_q;
    assign bus.broad_addr_o     = addr_q;
    assign bus.broad_type_o     = type_q;
    assign bus.broad_cpu_id_o   = cpu_q;
    assign bus.broad_id_o       = id_q;
endmodule

// File: tb/tb_mesi_isc_breq_arb.sv
// tb/tb_mesi_isc_breq_arb.sv - scoreboard bench for the broadcast request arbiter
module tb_mesi_isc_breq_arb;
    localparam int CW = 3;
    localparam int AW = 32;
    localparam int TW = 2;
    localparam int IW = 5;
    localparam logic [2:0] NOP = 3'd0, WR = 3'd1, RD = 3'd2, WRB = 3'd3, RDB = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mesi_isc_breq_arb_if #(.MBUS_CMD_WIDTH(CW), .ADDR_WIDTH(AW),
                           .BROAD_TYPE_WIDTH(TW), .BROAD_ID_WIDTH(IW)) bus ();

    mesi_isc_breq_arb #(.MBUS_CMD_WIDTH(CW), .ADDR_WIDTH(AW),
                        .BROAD_TYPE_WIDTH(TW), .BROAD_ID_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  typ;
        logic [1:0]  cpu;
        logic [4:0]  id;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   grants = 0;
    logic [1:0] last_cpu = 2'd0;
    logic [4:0] last_id  = 5'd0;

    logic [2:0]  post_cmd [4];
    logic [31:0] post_addr [4];
    int          post_seq [4] = '{0, 0, 0, 0};
    int          seen_seq [4] = '{0, 0, 0, 0};
    logic [3:0]  gen_mask  = 4'b0000;
    int          gen_pct   = 0;
    logic        gen_noise = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic post(input int n, input logic [2:0] c, input logic [31:0] a);
        post_cmd[n]  = c;
        post_addr[n] = a;
        post_seq[n]  = post_seq[n] + 1;
    endtask

    task automatic wait_grants(input int target, input int budget, input string name);
        int b = 0;
        while (grants < target && b < budget) begin
            @(posedge clk);
            b++;
        end
        checks++;
        if (grants < target) begin
            errors++;
            $display("FAIL %s: got %0d grants expected %0d within %0d cycles", name, grants, target, budget);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // CPU driver: holds a command until acked, then presents NOP or a fresh request.
    initial begin : driver
        logic [2:0]  cmd_r [4];
        logic [31:0] addr_r [4];
        for (int n = 0; n < 4; n++) begin
            cmd_r[n]  = NOP;
            addr_r[n] = 32'h0;
        end
        bus.mbus_cmd_array_i  = '0;
        bus.mbus_addr_array_i = '0;
        forever begin
            @(negedge clk);
            for (int n = 0; n < 4; n++) begin
                if (rst && bus.mbus_ack_array_o[n]) cmd_r[n] = NOP;
                if (post_seq[n] != seen_seq[n]) begin
                    cmd_r[n]    = post_cmd[n];
                    addr_r[n]   = post_addr[n];
                    seen_seq[n] = post_seq[n];
                end else if (gen_mask[n] && cmd_r[n] != WRB && cmd_r[n] != RDB &&
                             $urandom_range(0, 99) < gen_pct) begin
                    if (gen_noise) cmd_r[n] = 3'($urandom_range(1, 4));
                    else           cmd_r[n] = ($urandom_range(0, 1) != 0) ? WRB : RDB;
                    addr_r[n] = $urandom;
                end
                bus.mbus_cmd_array_i[n*CW +: CW]  = cmd_r[n];
                bus.mbus_addr_array_i[n*AW +: AW] = addr_r[n];
            end
        end
    end

    // Reference model: one grant per free slot, round-robin from the pointer, 3-cycle spacing.
    initial begin : model
        int         m_ptr;
        int         m_busy;
        logic [4:0] m_id;
        logic [2:0] c;
        bit         done;
        exp_t       e;
        m_ptr  = 0;
        m_busy = 0;
        m_id   = 5'd0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                q.delete();
                m_ptr  = 0;
                m_busy = 0;
                m_id   = 5'd0;
            end else if (m_busy > 0) begin
                m_busy--;
            end else if (!bus.broad_fifo_full_i) begin
                done = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = (m_ptr + k) % 4;
                    c   = bus.mbus_cmd_array_i[idx*CW +: CW];
                    if (!done && (c == WRB || c == RDB)) begin
                        done   = 1'b1;
                        e.addr = bus.mbus_addr_array_i[idx*AW +: AW];
                        e.typ  = (c == WRB) ? 2'd1 : 2'd2;
                        e.cpu  = 2'(idx);
                        e.id   = m_id;
                        e.tag  = cyc;
                        q.push_back(e);
                        m_id   = m_id + 5'd1;
                        m_ptr  = (idx + 1) % 4;
                        m_busy = 2;
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t        e;
        logic [31:0] h_addr;
        logic [1:0]  h_typ;
        logic [1:0]  h_cpu;
        logic [4:0]  h_id;
        h_addr = '0; h_typ = '0; h_cpu = '0; h_id = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                h_addr = '0; h_typ = '0; h_cpu = '0; h_id = '0;
            end else begin
                while (q.size() > 0 && q[0].tag < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_grant: got no write expected cpu %0d id %0d at cycle %0d",
                             q[0].cpu, q[0].id, q[0].tag);
                    void'(q.pop_front());
                end
                if (bus.broad_fifo_wr_o) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got write cpu %0d id %0d expected none",
                                 bus.broad_cpu_id_o, bus.broad_id_o);
                    end else begin
                        e = q.pop_front();
                        chk("grant_cycle", 32'(cyc), 32'(e.tag));
                        chk("broad_addr", bus.broad_addr_o, e.addr);
                        chk("broad_type", 32'(bus.broad_type_o), 32'(e.typ));
                        chk("broad_cpu_id", 32'(bus.broad_cpu_id_o), 32'(e.cpu));
                        chk("broad_id", 32'(bus.broad_id_o), 32'(e.id));
                        chk("mbus_ack", 32'(bus.mbus_ack_array_o), 32'(4'b0001 << e.cpu));
                        h_addr = e.addr; h_typ = e.typ; h_cpu = e.cpu; h_id = e.id;
                    end
                    grants++;
                    last_cpu = bus.broad_cpu_id_o;
                    last_id  = bus.broad_id_o;
                end else begin
                    chk("idle_ack", 32'(bus.mbus_ack_array_o), 32'h0);
                    chk("hold_addr", bus.broad_addr_o, h_addr);
                    chk("hold_type", 32'(bus.broad_type_o), 32'(h_typ));
                    chk("hold_cpu_id", 32'(bus.broad_cpu_id_o), 32'(h_cpu));
                    chk("hold_id", 32'(bus.broad_id_o), 32'(h_id));
                end
            end
        end
    end

    initial begin : main
        int  g0;
        bit  seen;
        bus.broad_fifo_full_i = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_wr", 32'(bus.broad_fifo_wr_o), 32'h0);
        chk("reset_ack", 32'(bus.mbus_ack_array_o), 32'h0);
        chk("reset_addr", bus.broad_addr_o, 32'h0);
        chk("reset_type", 32'(bus.broad_type_o), 32'h0);
        chk("reset_cpu_id", 32'(bus.broad_cpu_id_o), 32'h0);
        chk("reset_id", 32'(bus.broad_id_o), 32'h0);
        rst = 1'b1;

        // single read broadcast from CPU2
        g0 = grants;
        post(2, RDB, 32'h0000_1040);
        wait_grants(g0 + 1, 20, "cpu2_rd_broad");
        chk("cpu2_cpu_id", 32'(last_cpu), 32'd2);
        chk("cpu2_id", 32'(last_id), 32'd0);
        repeat (5) @(negedge clk);

        // all four request from reset
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) post(n, WRB, 32'h100 * n + 32'hA000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        g0 = grants;
        wait_grants(g0 + 4, 30, "four_cpu_rr");
        repeat (10) @(negedge clk);
        chk("four_cpu_once", 32'(grants - g0), 32'd4);

        // full stall
        reset_dut();
        g0 = grants;
        post(0, WRB, 32'h0000_2000);
        wait_grants(g0 + 1, 20, "pre_stall_grant");
        @(negedge clk);
        bus.broad_fifo_full_i = 1'b1;
        post(1, RDB, 32'h0000_3000);
        repeat (10) @(negedge clk);
        chk("full_no_grant", 32'(grants - g0), 32'd1);
        bus.broad_fifo_full_i = 1'b0;
        wait_grants(g0 + 2, 20, "post_stall_grant");
        chk("post_stall_cpu", 32'(last_cpu), 32'd1);
        chk("post_stall_id", 32'(last_id), 32'd1);
        repeat (5) @(negedge clk);

        // id counter wrap with CPU3
        reset_dut();
        g0 = grants;
        gen_mask = 4'b1000;
        gen_pct  = 100;
        wait_grants(g0 + 33, 33 * 4 + 20, "cpu3_33_grants");
        chk("wrap_cpu", 32'(last_cpu), 32'd3);
        chk("wrap_id", 32'(last_id), 32'd0);
        gen_mask = 4'b0000;
        repeat (10) @(negedge clk);

        // plain WR/RD are never granted
        reset_dut();
        g0 = grants;
        post(0, WR, 32'h0000_4000);
        repeat (10) @(negedge clk);
        post(0, RD, 32'h0000_5000);
        repeat (10) @(negedge clk);
        chk("wr_rd_ignored", 32'(grants - g0), 32'd0);
        post(0, NOP, 32'h0);

        // reset asserted during ISSUE
        reset_dut();
        post(1, WRB, 32'h0000_6000);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (bus.broad_fifo_wr_o) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL issue_before_reset: got no write expected one within 20 cycles");
        end
        rst = 1'b0;
        #1;
        chk("async_reset_wr", 32'(bus.broad_fifo_wr_o), 32'h0);
        chk("async_reset_ack", 32'(bus.mbus_ack_array_o), 32'h0);
        @(negedge clk);
        for (int n = 0; n < 4; n++) post(n, WRB, 32'h0000_7000 + 32'(n));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        g0 = grants;
        wait_grants(g0 + 1, 20, "after_reset_grant");
        chk("after_reset_cpu", 32'(last_cpu), 32'd0);
        chk("after_reset_id", 32'(last_id), 32'd0);
        repeat (15) @(negedge clk);

        // randomized traffic with random full
        reset_dut();
        gen_mask  = 4'b1111;
        gen_pct   = 30;
        gen_noise = 1'b1;
        repeat (1500) begin
            @(negedge clk);
            bus.broad_fifo_full_i = ($urandom_range(0, 3) == 0);
        end
        bus.broad_fifo_full_i = 1'b0;
        gen_mask = 4'b0000;
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mesi_isc_breq_arb.md
Name: mesi_isc_breq_arb

Overview:
- Upstream feeder of the broadcast stage.
- Samples the four CPUs' main-bus commands and selects one broadcast-class request per grant with round-robin arbitration.
- Writes the selected request into the broadcast request FIFO as {address, type, initiator CPU id, broadcast id}.
- Acknowledges the granted CPU and honours the FIFO full status.

Parameters:
- MBUS_CMD_WIDTH, 3, width of one CPU main-bus command.
- ADDR_WIDTH, 32, address width.
- BROAD_TYPE_WIDTH, 2, broadcast type field width.
- BROAD_ID_WIDTH, 5, broadcast id counter width.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- mbus_cmd_array_i  input  4*MBUS_CMD_WIDTH  per-CPU command; CPU n occupies bits [n*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH].
- mbus_addr_array_i  input  4*ADDR_WIDTH  per-CPU address; CPU n occupies bits [n*ADDR_WIDTH +: ADDR_WIDTH].
- broad_fifo_full_i  input  1  broadcast FIFO full status.
- mbus_ack_array_o  output  4  one-hot acknowledge to the granted CPU.
- broad_fifo_wr_o  output  1  write strobe into the broadcast FIFO.
- broad_addr_o  output  ADDR_WIDTH  address of the granted request.
- broad_type_o  output  BROAD_TYPE_WIDTH  1 = write broadcast, 2 = read broadcast.
- broad_cpu_id_o  output  2  initiator CPU index.
- broad_id_o  output  BROAD_ID_WIDTH  broadcast request id.

Behaviour:
- Command encoding:
  - NOP = 0, WR = 1, RD = 2, WR_BROAD = 3, RD_BROAD = 4.
  - Only WR_BROAD and RD_BROAD are requests for this block.
  - All other codes are ignored and never acked here.
- Reset (rst low, asynchronous):
  - All outputs go to 0 immediately.
  - State = IDLE, broadcast id counter = 0.
  - Priority pointer set so CPU0 has highest priority.
  - Deasserting reset is synchronous to clk.
- FSM states: IDLE, ISSUE, COOL. Every output is registered.
- IDLE:
  - If broad_fifo_full_i == 0 and at least one CPU presents WR_BROAD/RD_BROAD, select the winner.
  - Winner = first requesting CPU scanning from the pointer upward, modulo 4.
  - Capture the winner's address, type (WR_BROAD→1, RD_BROAD→2), CPU index and the current id counter. Go to ISSUE.
  - Otherwise stay in IDLE with all strobes 0.
- ISSUE (exactly 1 cycle):
  - broad_fifo_wr_o = 1 and mbus_ack_array_o[winner] = 1.
  - Data outputs hold the captured values.
  - At the end of the cycle: id counter +1 (wraps 2^BROAD_ID_WIDTH−1 → 0), pointer = winner+1 mod 4. Go to COOL.
- COOL (exactly 1 cycle):
  - Strobes 0. The acked CPU must present NOP or a new command from the next cycle on.
  - Go to IDLE.
- Latency and throughput:
  - A request present in IDLE produces the FIFO write and ack 1 cycle later.
  - Maximum rate is 1 grant per 3 cycles.
- CPU handshake: a CPU holds its command and address stable until it receives its ack. A change before the ack is legal; only the values sampled in IDLE are used.
- Full handling:
  - Full is sampled only in IDLE.
  - The 3-cycle grant spacing guarantees the FIFO full flag reflects the previous write before the next sample.
  - While full, requests wait, no ack is issued, and the pointer and id do not change.
- Simultaneous requests: exactly one grant per ISSUE; the others keep waiting. The rotating pointer bounds starvation to 3 grants.
- Outside ISSUE, data outputs hold their last values. Only the strobes return to 0.
- Reset during ISSUE or COOL aborts the operation: no write or ack is produced after reset asserts.

Test Plan:
- Reset, then CPU2 drives RD_BROAD at addr 0x0000_1040 → 1 cycle later: broad_fifo_wr_o=1, broad_addr_o=0x0000_1040, broad_type_o=2, broad_cpu_id_o=2, broad_id_o=0, mbus_ack_array_o=4'b0100 for 1 cycle.
- All four CPUs hold WR_BROAD from reset → grants in order CPU0,1,2,3 every 3 cycles, ids 0,1,2,3, broad_type_o=1, each CPU acked once.
- broad_fifo_full_i=1 with CPU1 requesting for 10 cycles → no write, no ack. Deassert full → write plus ack 1 cycle after the first IDLE sample; id unchanged from before the stall.
- 32 consecutive grants from CPU3 → broad_id_o runs 0..31, then the 33rd grant carries id 0.
- CPU0 issues WR (1) and RD (2) only → no write, no ack ever.
- Assert rst in ISSUE → broad_fifo_wr_o and ack drop to 0 asynchronously. After release, CPU0 has priority and the id counter is 0.
